// File: rtl/lsu_byte_master_if.sv
// lsu_byte_master_if: CPU request side and byte-wide memory bus of lsu_byte_master.
interface lsu_byte_master_if #(parameter int AW = 5);
  logic          req_i;
  logic          we_i;
  logic [31:0]   addr_i;
  logic [31:0]   wdata_i;
  logic          busy_o;
  logic          done_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_re_o;
  logic          mem_we_o;
  logic [7:0]    mem_wdata_o;
  logic [7:0]    mem_rdata_i;
  modport master (
    input  req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    output busy_o, done_o, rdata_o, err_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
  );
  modport slave (
    output req_i, we_i, addr_i, wdata_i, mem_rdata_i,
    input  busy_o, done_o, rdata_o, err_o, mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o
  );
endinterface

// File: rtl/lsu_byte_master.sv
// lsu_byte_master: serialises one lw/sw into four little-endian byte transfers.
// Define LSU_MISALIGN_CHK_EN to reject requests with addr[1:0]!=0 via err_o.
module lsu_byte_master #(
  parameter int MEM_BYTES = 32,
  parameter int AW = $clog2(MEM_BYTES)
) (
  input logic clk_i,
  input logic rst_i,
  lsu_byte_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_TAIL, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] b_q;
  logic [AW-1:0] base_q;
  logic [31:0] wdata_q;
  logic [23:0] shadow_q;
  logic [31:0] rdata_q;
  logic misalign;
  logic accept;
  logic unused_addr;
  assign unused_addr = ^bus.addr_i[31:AW];
  assign accept = state_q == IDLE && bus.req_i;
`ifdef LSU_MISALIGN_CHK_EN
  logic err_q;
  assign misalign = bus.addr_i[1:0] != 2'b00;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  assign bus.err_o = state_q == DONE && err_q;
`else
  assign misalign = 1'b0;
  assign bus.err_o = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q  <= IDLE;
      b_q      <= 2'd0;
      base_q   <= '0;
      wdata_q  <= 32'd0;
      shadow_q <= 24'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      b_q     <= (state_q == WR || state_q == RD) ? b_q + 2'd1 : 2'd0;
      if (accept) begin
        base_q  <= bus.addr_i[AW-1:0];
        wdata_q <= bus.wdata_i;
      end
      // read data lags the address by one cycle, so bytes 0..2 shift in during C2..C4
      if (state_q == RD && b_q != 2'd0) shadow_q <= {bus.mem_rdata_i, shadow_q[23:8]};
      if (state_q == RD_TAIL) rdata_q <= {bus.mem_rdata_i, shadow_q};
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_i) state_d = misalign ? DONE : (bus.we_i ? WR : RD);
      WR:      state_d = b_q == 2'd3 ? DONE : WR;
      RD:      state_d = b_q == 2'd3 ? RD_TAIL : RD;
      RD_TAIL: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy_o      = state_q != IDLE;
  assign bus.done_o      = state_q == DONE;
  assign bus.mem_we_o    = state_q == WR;
  assign bus.mem_re_o    = state_q == RD;
  assign bus.mem_addr_o  = (bus.mem_we_o || bus.mem_re_o) ? base_q + AW'(b_q) : '0;
  assign bus.mem_wdata_o = bus.mem_we_o ? 8'(wdata_q >> {b_q, 3'b000}) : 8'd0;
  assign bus.rdata_o     = rdata_q;
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: random and directed lw/sw traffic against a byte-array reference memory.
module tb_lsu_byte_master;
  localparam int MB = 32;
  localparam int AW = 5;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;
  lsu_byte_master_if #(.AW(AW)) bus ();
  lsu_byte_master #(.MEM_BYTES(MB)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  logic [7:0] mem [MB];
  logic [7:0] ref_mem [MB];
  logic [7:0] rd_q;
  logic mem_clr;
  logic [31:0] ref_rdata;
  int vectors = 0;
  int miscompares = 0;
  always @(posedge clk_i) begin
    if (mem_clr) for (int i = 0; i < MB; i++) mem[i] <= 8'h00;
    else if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
    if (bus.mem_re_o) rd_q <= mem[bus.mem_addr_o];
  end
  assign bus.mem_rdata_i = rd_q;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic mem_check();
    int bad = 0;
    for (int i = 0; i < MB; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, bus.busy_o, 0);
    check({tag, "_done"}, bus.done_o, 0);
    check({tag, "_err"}, bus.err_o, 0);
    check({tag, "_we"}, bus.mem_we_o, 0);
    check({tag, "_re"}, bus.mem_re_o, 0);
    check({tag, "_addr"}, bus.mem_addr_o, 0);
    check({tag, "_wdata"}, bus.mem_wdata_o, 0);
    check({tag, "_rdata"}, bus.rdata_o, ref_rdata);
  endtask
  // one full transfer; pulse raises a stray req_i during C2
  task automatic xfer(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic pulse);
    int base;
    bit mis;
    int dc;
    logic [31:0] word;
    bit act;
    base = int'(a % MB);
    mis = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    mis = a[1:0] != 2'b00;
`endif
    dc = mis ? 1 : (we ? 5 : 6);
    for (int i = 0; i < 4; i++) word[8*i +: 8] = ref_mem[(base + i) % MB];
    @(negedge clk_i);
    check("idle_busy", bus.busy_o, 0);
    bus.req_i = 1'b1;
    bus.we_i = we;
    bus.addr_i = a;
    bus.wdata_i = wd;
    for (int k = 1; k <= dc + 1; k++) begin
      @(negedge clk_i);
      bus.req_i = pulse && k == 2;
      if (bus.req_i) begin
        bus.we_i = 1'($urandom);
        bus.addr_i = $urandom;
      end
      if (k == dc && !we && !mis) ref_rdata = word;
      act = !mis && k <= 4;
      check("busy", bus.busy_o, k <= dc);
      check("done", bus.done_o, k == dc);
      check("err", bus.err_o, mis && k == dc);
      check("mem_we", bus.mem_we_o, act && we);
      check("mem_re", bus.mem_re_o, act && !we);
      check("mem_addr", bus.mem_addr_o, act ? 32'((base + k - 1) % MB) : 32'd0);
      check("mem_wdata", bus.mem_wdata_o, (act && we) ? 32'(wd[8*(k-1) +: 8]) : 32'd0);
      check("rdata", bus.rdata_o, ref_rdata);
    end
    if (we && !mis) for (int i = 0; i < 4; i++) ref_mem[(base + i) % MB] = wd[8*i +: 8];
    mem_check();
  endtask
  initial begin
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = 32'd0;
    bus.wdata_i = 32'd0;
    mem_clr = 1'b1;
    ref_rdata = 32'd0;
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    #1;
    check_quiet("reset");
    repeat (2) @(negedge clk_i);
    mem_clr = 1'b0;
    rst_i = 1'b1;
    xfer(1'b1, 32'h08, 32'hDEADBEEF, 1'b0);
    xfer(1'b0, 32'h08, 32'h0, 1'b0);
    xfer(1'b1, 32'h14, 32'h01020304, 1'b0);
    xfer(1'b1, 32'd30, 32'h11223344, 1'b0);
    xfer(1'b0, 32'd30, 32'h0, 1'b0);
    xfer(1'b0, 32'hFFFF_FF08, 32'h0, 1'b1);
    @(negedge clk_i);
    bus.req_i = 1'b1;
    bus.we_i = 1'b1;
    bus.addr_i = 32'h04;
    bus.wdata_i = 32'hCAFEF00D;
    @(negedge clk_i);
    bus.req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    ref_rdata = 32'd0;
    ref_mem[4] = 8'h0D;
    ref_mem[5] = 8'hF0;
    check_quiet("midreset");
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check_quiet("postreset");
    end
    mem_check();
`ifdef LSU_MISALIGN_CHK_EN
    xfer(1'b0, 32'h05, 32'h0, 1'b0);
`endif
    for (int n = 0; n < 30; n++) xfer(1'($urandom), $urandom, $urandom, 1'($urandom));
    for (int n = 0; n < 8; n++) xfer(1'b0, $urandom, 32'h0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
